// File: rtl/alu_cmd_issue_pkg.sv
// Shared definitions for the ALU command issue stage: opcodes, default width,
// FSM state encoding and a small sizing helper.
package alu_cmd_issue_pkg;

   localparam int DATA_W_DEF = 4;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_SUB = 2'b01;
   localparam logic [1:0] ALUOP_AND = 2'b10;
   localparam logic [1:0] ALUOP_OR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Wait counter must hold the value ALU_LAT; never narrower than one bit.
   function automatic int cnt_width(input int lat);
      return (lat < 1) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with combinational head read; storage is not reset,
// only the pointers and occupancy count are.
module alu_cmd_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == FULL_CNT);
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command issue stage in front of the registered ALU: buffers commands, issues
// one at a time, waits out the ALU latency and holds the result for the consumer.
module alu_cmd_issue
   import alu_cmd_issue_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_a,
   input  logic [DATA_W-1:0] cmd_b,
   input  logic [1:0]        cmd_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic [1:0]        res_op
);
   localparam int ENTRY_W = 2 * DATA_W + 2;
   localparam int CNT_W   = cnt_width(ALU_LAT);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT);

   logic [ENTRY_W-1:0]     fifo_din;
   logic [ENTRY_W-1:0]     fifo_dout;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   logic                   unused_count;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [DATA_W-1:0] alu_a_reg, alu_a_next;
   logic [DATA_W-1:0] alu_b_reg, alu_b_next;
   logic [1:0]        alu_op_reg, alu_op_next;
   logic [DATA_W-1:0] res_data_reg, res_data_next;
   logic [1:0]        res_op_reg, res_op_next;
   logic              res_valid_reg, res_valid_next;
   logic              issue;

   assign fifo_din     = {cmd_op, cmd_a, cmd_b};
   assign fifo_push    = cmd_valid && !fifo_full;
   assign fifo_pop     = issue;
   assign unused_count = ^fifo_count;

   alu_cmd_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      alu_a_next     = alu_a_reg;
      alu_b_next     = alu_b_reg;
      alu_op_next    = alu_op_reg;
      res_data_next  = res_data_reg;
      res_op_next    = res_op_reg;
      res_valid_next = res_valid_reg;
      issue          = 1'b0;
      case (state_reg)
         IDLE: issue = !fifo_empty;
         WAIT: begin
            if (cnt_reg == '0) begin
               res_data_next  = alu_result;
               res_op_next    = alu_op_reg;
               res_valid_next = 1'b1;
               state_next     = HOLD;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_next = 1'b0;
               issue          = !fifo_empty;
               if (fifo_empty) state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      // Issue from IDLE or back-to-back from HOLD shares one load path.
      if (issue) begin
         alu_op_next = fifo_dout[ENTRY_W-1 -: 2];
         alu_a_next  = fifo_dout[2*DATA_W-1 -: DATA_W];
         alu_b_next  = fifo_dout[DATA_W-1:0];
         cnt_next    = LAT_LOAD;
         state_next  = WAIT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         alu_a_reg     <= '0;
         alu_b_reg     <= '0;
         alu_op_reg    <= '0;
         res_data_reg  <= '0;
         res_op_reg    <= '0;
         res_valid_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         alu_a_reg     <= alu_a_next;
         alu_b_reg     <= alu_b_next;
         alu_op_reg    <= alu_op_next;
         res_data_reg  <= res_data_next;
         res_op_reg    <= res_op_next;
         res_valid_reg <= res_valid_next;
      end
   end

   assign cmd_ready = !fifo_full;
   assign alu_a     = alu_a_reg;
   assign alu_b     = alu_b_reg;
   assign alu_op    = alu_op_reg;
   assign res_valid = res_valid_reg;
   assign res_data  = res_data_reg;
   assign res_op    = res_op_reg;

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: a registered ALU model drives alu_result and each
// scenario task checks results against arithmetic computed from the command.
module tb_alu_cmd_issue;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_a = '0;
   logic [3:0] cmd_b = '0;
   logic [1:0] cmd_op = '0;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [1:0] alu_op;
   logic [3:0] alu_result;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [3:0] res_data;
   logic [1:0] res_op;

   logic [3:0] alu_core = '0;
   logic [3:0] noise = '0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_cmd_issue dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_op     (res_op)
   );

   function automatic logic [3:0] ref_result(input int a, input int b, input int op);
      case (op)
         0:       return 4'((a + b) % 16);
         1:       return 4'((a - b + 16) % 16);
         2:       return 4'(a & b);
         default: return 4'(a | b);
      endcase
   endfunction

   // Registered ALU with one edge of latency; noise lets a test disturb its output.
   always @(posedge clk) alu_core <= ref_result(int'(alu_a), int'(alu_b), int'(alu_op));
   assign alu_result = alu_core ^ noise;

   task automatic test_reset();
      rst = 1'b1;
      #1;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid_in_rst: got %0b want 0", res_valid); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); end
      n_cmp++; if ({res_valid, res_data, res_op} !== 7'd0) begin n_err++; $display("FAIL reset_res: got %b want 0", {res_valid, res_data, res_op}); end
      n_cmp++; if ({alu_a, alu_b, alu_op} !== 10'd0) begin n_err++; $display("FAIL reset_alu: got %b want 0", {alu_a, alu_b, alu_op}); end
      $display("reset: released");
   endtask

   task automatic test_single_add();
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 4'd9; cmd_b = 4'd8; cmd_op = 2'b00;
      @(negedge clk);
      cmd_valid = 1'b0;
      n_cmp++; if (alu_a !== 4'd0) begin n_err++; $display("FAIL add_no_bypass: alu_a got %0d want 0", alu_a); end
      @(negedge clk);
      n_cmp++; if ({alu_a, alu_b, alu_op} !== {4'd9, 4'd8, 2'b00}) begin n_err++; $display("FAIL add_issue: got %0d/%0d/%0d want 9/8/0", alu_a, alu_b, alu_op); end
      @(negedge clk);
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_early_valid: got %0b want 0", res_valid); end
      @(negedge clk);
      n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL add_valid: got %0b want 1", res_valid); end
      n_cmp++; if ({res_data, res_op} !== {ref_result(9, 8, 0), 2'b00}) begin n_err++; $display("FAIL add_data: got %0d op %0d want 1 op 0", res_data, res_op); end
      $display("single_add: 9+8 -> %0d", res_data);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL add_consumed: got %0b want 0", res_valid); end
      n_cmp++; if ({alu_a, alu_b} !== {4'd9, 4'd8}) begin n_err++; $display("FAIL add_alu_hold: got %0d/%0d want 9/8", alu_a, alu_b); end
   endtask

   task automatic test_sequence();
      logic [9:0] cmds [3];
      int t [3];
      int k;
      cmds[0] = {2'b01, 4'd3, 4'd5};
      cmds[1] = {2'b10, 4'd12, 4'd10};
      cmds[2] = {2'b11, 4'd12, 4'd3};
      k = 0;
      res_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid && k < 3) begin
            n_cmp++;
            if ({res_op, res_data} !== {cmds[k][9:8], ref_result(int'(cmds[k][7:4]), int'(cmds[k][3:0]), int'(cmds[k][9:8]))}) begin
               n_err++; $display("FAIL seq_data%0d: got op %0d data %0d want op %0d data %0d", k, res_op, res_data,
                  cmds[k][9:8], ref_result(int'(cmds[k][7:4]), int'(cmds[k][3:0]), int'(cmds[k][9:8])));
            end
            $display("sequence: result %0d data %0d at cycle %0d", k, res_data, i);
            t[k] = i;
            k++;
         end
         cmd_valid = (i < 3);
         if (i < 3) {cmd_op, cmd_a, cmd_b} = cmds[i];
      end
      res_ready = 1'b0;
      n_cmp++; if (k !== 3) begin n_err++; $display("FAIL seq_count: got %0d want 3", k); end
      if (k == 3) begin
         n_cmp++; if (t[0] !== 4) begin n_err++; $display("FAIL seq_first_latency: got %0d want 4", t[0]); end
         n_cmp++; if (t[1] - t[0] !== 3 || t[2] - t[1] !== 3) begin n_err++; $display("FAIL seq_spacing: got %0d,%0d want 3,3", t[1] - t[0], t[2] - t[1]); end
      end
   endtask

   task automatic test_backpressure();
      logic [9:0] cmds [6];
      logic [5:0] expq [$];
      logic [5:0] e;
      int pushed, got;
      bit fire;
      pushed = 0; got = 0; fire = 1'b0;
      for (int i = 0; i < 6; i++) cmds[i] = 10'($urandom);
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (fire) begin
            expq.push_back({cmd_op, ref_result(int'(cmd_a), int'(cmd_b), int'(cmd_op))});
            pushed++;
         end
         if (i == 8) begin
            n_cmp++; if (pushed !== 5) begin n_err++; $display("FAIL bp_accepted: got %0d want 5", pushed); end
            n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: cmd_ready got %0b want 0", cmd_ready); end
            n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid: got %0b want 1", res_valid); end
         end
         res_ready = (i >= 10);
         if (res_valid && res_ready) begin
            n_cmp++;
            if (expq.size() == 0) begin
               n_err++; $display("FAIL bp_extra: unexpected result %0d want none", res_data);
            end else begin
               e = expq.pop_front();
               if ({res_op, res_data} !== e) begin n_err++; $display("FAIL bp_data%0d: got %h want %h", got, {res_op, res_data}, e); end
            end
            $display("backpressure: result %0d data %0d", got, res_data);
            got++;
         end
         cmd_valid = (pushed < 6);
         if (pushed < 6) {cmd_op, cmd_a, cmd_b} = cmds[pushed];
         fire = cmd_valid && cmd_ready;
      end
      res_ready = 1'b0;
      n_cmp++; if (got !== 6 || expq.size() !== 0) begin n_err++; $display("FAIL bp_drain: got %0d results want 6", got); end
   endtask

   task automatic test_push_pop();
      res_ready = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b1; {cmd_op, cmd_a, cmd_b} = {2'b00, 4'd1, 4'd2};
      @(negedge clk);
      {cmd_op, cmd_a, cmd_b} = {2'b01, 4'd7, 4'd4};
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({res_valid, res_data} !== {1'b1, 4'd3}) begin n_err++; $display("FAIL pp_first: got v%0b d%0d want v1 d3", res_valid, res_data); end
      n_cmp++; if (dut.u_fifo.count !== 3'd1) begin n_err++; $display("FAIL pp_count_before: got %0d want 1", dut.u_fifo.count); end
      cmd_valid = 1'b1; {cmd_op, cmd_a, cmd_b} = {2'b10, 4'd6, 4'd3};
      @(negedge clk);
      cmd_valid = 1'b0;
      n_cmp++; if (dut.u_fifo.count !== 3'd1) begin n_err++; $display("FAIL pp_count_after: got %0d want 1", dut.u_fifo.count); end
      n_cmp++; if ({alu_a, alu_b, alu_op} !== {4'd7, 4'd4, 2'b01}) begin n_err++; $display("FAIL pp_issue: got %0d/%0d/%0d want 7/4/1", alu_a, alu_b, alu_op); end
      repeat (2) @(negedge clk);
      n_cmp++; if ({res_valid, res_op, res_data} !== {1'b1, 2'b01, 4'd3}) begin n_err++; $display("FAIL pp_second: got v%0b op%0d d%0d want v1 op1 d3", res_valid, res_op, res_data); end
      repeat (3) @(negedge clk);
      n_cmp++; if ({res_valid, res_op, res_data} !== {1'b1, 2'b10, 4'd2}) begin n_err++; $display("FAIL pp_third: got v%0b op%0d d%0d want v1 op2 d2", res_valid, res_op, res_data); end
      $display("push_pop: third result %0d", res_data);
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL pp_idle: got %0b want 0", res_valid); end
   endtask

   task automatic test_reset_wait();
      int w;
      @(negedge clk);
      cmd_valid = 1'b1; {cmd_op, cmd_a, cmd_b} = {2'b00, 4'd6, 4'd11};
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if ({res_valid, alu_a, alu_b, alu_op} !== 11'd0) begin n_err++; $display("FAIL rw_async: got %b want 0", {res_valid, alu_a, alu_b, alu_op}); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if ({cmd_ready, res_valid, res_data, res_op} !== 8'b1000_0000) begin n_err++; $display("FAIL rw_after: got %b want 10000000", {cmd_ready, res_valid, res_data, res_op}); end
      w = 0;
      repeat (6) begin @(negedge clk); if (res_valid) w++; end
      n_cmp++; if (w !== 0) begin n_err++; $display("FAIL rw_ghost: got %0d valid cycles want 0", w); end
      cmd_valid = 1'b1; {cmd_op, cmd_a, cmd_b} = {2'b01, 4'd7, 4'd2};
      @(negedge clk);
      cmd_valid = 1'b0;
      w = 0;
      while (!res_valid && w < 20) begin @(negedge clk); w++; end
      n_cmp++; if ({res_valid, res_op, res_data} !== {1'b1, 2'b01, 4'd5}) begin n_err++; $display("FAIL rw_new: got v%0b op%0d d%0d want v1 op1 d5", res_valid, res_op, res_data); end
      $display("reset_wait: new result %0d", res_data);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_stable_hold();
      int w;
      int bad;
      logic [5:0] e;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
      e = {cmd_op, ref_result(int'(cmd_a), int'(cmd_b), int'(cmd_op))};
      @(negedge clk);
      cmd_valid = 1'b0;
      w = 0;
      while (!res_valid && w < 20) begin @(negedge clk); w++; end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         noise = 4'($urandom_range(1, 15));
         @(negedge clk);
         if ({res_valid, res_op, res_data} !== {1'b1, e}) bad++;
      end
      noise = '0;
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL hold_stable: got %0d unstable cycles (now v%0b %h) want 0 (%h)", bad, res_valid, {res_op, res_data}, e); end
      $display("stable_hold: held %h", {res_op, res_data});
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: got %0b want 0", res_valid); end
   endtask

   task automatic test_random();
      logic [5:0] expq [$];
      logic [5:0] e;
      int pushed, got;
      bit fire;
      pushed = 0; got = 0; fire = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (fire) begin
            expq.push_back({cmd_op, ref_result(int'(cmd_a), int'(cmd_b), int'(cmd_op))});
            pushed++;
         end
         res_ready = ($urandom_range(0, 99) < 60);
         if (res_valid && res_ready) begin
            n_cmp++;
            if (expq.size() == 0) begin
               n_err++; $display("FAIL rnd_extra: unexpected result %0d want none", res_data);
            end else begin
               e = expq.pop_front();
               if ({res_op, res_data} !== e) begin n_err++; $display("FAIL rnd_data%0d: got %h want %h", got, {res_op, res_data}, e); end
            end
            $display("random: result %0d data %0d op %0d", got, res_data, res_op);
            got++;
         end
         if (pushed == 40) cmd_valid = 1'b0;
         if (got == 40) break;
         if (!(cmd_valid && !fire) && pushed < 40) begin
            cmd_valid = ($urandom_range(0, 99) < 70);
            cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_op = 2'($urandom);
         end
         fire = cmd_valid && cmd_ready;
      end
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++; if (got !== 40 || expq.size() !== 0) begin n_err++; $display("FAIL rnd_total: got %0d results want 40", got); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      test_reset();
      test_single_add();
      test_sequence();
      test_backpressure();
      test_push_pop();
      test_reset_wait();
      test_stable_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
